// File: rtl/uart_param_if.sv
// Byte-wide system-side bus of uart_param: TX write port, RX show-ahead read
// port and the two FIFO status flags.
interface uart_param_if #(
  parameter int DBIT = 8
);
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic            rd_uart;
  logic [DBIT-1:0] r_data;
  logic            tx_full;
  logic            rx_empty;

  modport master (
    output wr_uart, w_data, rd_uart,
    input  r_data, tx_full, rx_empty
  );

  modport slave (
    input  wr_uart, w_data, rd_uart,
    output r_data, tx_full, rx_empty
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: shared baud tick, 16x-oversampled RX/TX FSMs,
// a FIFO on each side and sticky parity/framing/overrun flags.
module uart_param_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_i,
  input  logic [DW-1:0] w_data_i,
  input  logic          rd_i,
  output logic [DW-1:0] r_data_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A write on full only proceeds if the head is leaving in the same clock.
  assign do_rd   = rd_i && !empty_o;
  assign do_wr   = wr_i && (!full_o || rd_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, do_wr};
      rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, do_rd};
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, and r_data_o is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= w_data_i;
  end

  assign r_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

module uart_param #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        par_mode,
  uart_param_if.slave       bus,
  input  logic              rx,
  output logic              tx,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_err
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam int TW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW = $clog2(DBIT);
  localparam logic [TW-1:0] T_HALF     = TW'(7);
  localparam logic [TW-1:0] T_BIT_END  = TW'(15);
  localparam logic [TW-1:0] T_STOP_END = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  logic par_en, par_odd;
  assign par_en  = (par_mode == 2'b01) || (par_mode == 2'b10);
  assign par_odd = (par_mode == 2'b01);

  // Baud generator; >= lets a freshly lowered dvsr take effect at once.
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              tick;
  assign tick  = (cnt_q >= dvsr);
  assign cnt_d = tick ? '0 : cnt_q + DVSR_W'(1);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  logic rx_meta_q, rx_sync_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  state_e          rx_state_q;
  logic [TW-1:0]   rx_s_q;
  logic [NW-1:0]   rx_n_q;
  logic [DBIT-1:0] rx_b_q;
  logic            rx_push, rx_full, rx_par_bad, rx_frame_bad, rx_ovr;

  assign rx_push      = (rx_state_q == S_STOP) && tick && (rx_s_q == T_STOP_END);
  assign rx_frame_bad = rx_push && !rx_sync_q;
  assign rx_par_bad   = (rx_state_q == S_PARITY) && tick && (rx_s_q == T_BIT_END) &&
                        ((^rx_b_q ^ rx_sync_q) != par_odd);
  assign rx_ovr       = rx_push && rx_full && !bus.rd_uart;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
    end else begin
      case (rx_state_q)
        S_IDLE: if (!rx_sync_q) begin
          rx_state_q <= S_START;
          rx_s_q     <= '0;
        end
        S_START: if (tick) begin
          if (rx_s_q == T_HALF) begin
            // A start bit that does not survive to mid-bit is line noise.
            if (!rx_sync_q) begin
              rx_state_q <= S_DATA;
              rx_s_q     <= '0;
              rx_n_q     <= '0;
            end else begin
              rx_state_q <= S_IDLE;
            end
          end else rx_s_q <= rx_s_q + TW'(1);
        end
        S_DATA: if (tick) begin
          if (rx_s_q == T_BIT_END) begin
            rx_s_q <= '0;
            rx_b_q <= {rx_sync_q, rx_b_q[DBIT-1:1]};
            if (rx_n_q == N_LAST) rx_state_q <= par_en ? S_PARITY : S_STOP;
            else                  rx_n_q     <= rx_n_q + NW'(1);
          end else rx_s_q <= rx_s_q + TW'(1);
        end
        S_PARITY: if (tick) begin
          if (rx_s_q == T_BIT_END) begin
            rx_s_q     <= '0;
            rx_state_q <= S_STOP;
          end else rx_s_q <= rx_s_q + TW'(1);
        end
        S_STOP: if (tick) begin
          if (rx_s_q == T_STOP_END) rx_state_q <= S_IDLE;
          else                      rx_s_q     <= rx_s_q + TW'(1);
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  uart_param_fifo #(.DW(DBIT), .AW(FIFO_W)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (rx_push),
    .w_data_i (rx_b_q),
    .rd_i     (bus.rd_uart),
    .r_data_o (bus.r_data),
    .full_o   (rx_full),
    .empty_o  (bus.rx_empty)
  );

  state_e          tx_state_q;
  logic [TW-1:0]   tx_s_q;
  logic [NW-1:0]   tx_n_q;
  logic [DBIT-1:0] tx_b_q;
  logic            tx_par_q, tx_q;
  logic [DBIT-1:0] tx_head;
  logic            tx_empty, tx_frame_end, tx_pop;

  // Popping on the last stop tick chains frames with no idle gap.
  assign tx_frame_end = (tx_state_q == S_STOP) && tick && (tx_s_q == T_STOP_END);
  assign tx_pop       = !tx_empty && ((tx_state_q == S_IDLE) || tx_frame_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= tx_head;
      tx_par_q   <= ^tx_head;
      tx_q       <= 1'b0;
    end else begin
      case (tx_state_q)
        S_IDLE: tx_q <= 1'b1;
        S_START: if (tick) begin
          if (tx_s_q == T_BIT_END) begin
            tx_state_q <= S_DATA;
            tx_s_q     <= '0;
            tx_q       <= tx_b_q[0];
          end else tx_s_q <= tx_s_q + TW'(1);
        end
        S_DATA: if (tick) begin
          if (tx_s_q == T_BIT_END) begin
            tx_s_q <= '0;
            tx_b_q <= tx_b_q >> 1;
            if (tx_n_q == N_LAST) begin
              tx_state_q <= par_en ? S_PARITY : S_STOP;
              tx_q       <= par_en ? (tx_par_q ^ par_odd) : 1'b1;
            end else begin
              tx_n_q <= tx_n_q + NW'(1);
              tx_q   <= tx_b_q[1];
            end
          end else tx_s_q <= tx_s_q + TW'(1);
        end
        S_PARITY: if (tick) begin
          if (tx_s_q == T_BIT_END) begin
            tx_state_q <= S_STOP;
            tx_s_q     <= '0;
            tx_q       <= 1'b1;
          end else tx_s_q <= tx_s_q + TW'(1);
        end
        S_STOP: if (tick) begin
          if (tx_s_q == T_STOP_END) tx_state_q <= S_IDLE;
          else                      tx_s_q     <= tx_s_q + TW'(1);
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  assign tx = tx_q;

  uart_param_fifo #(.DW(DBIT), .AW(FIFO_W)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (bus.wr_uart),
    .w_data_i (bus.w_data),
    .rd_i     (tx_pop),
    .r_data_o (tx_head),
    .full_o   (bus.tx_full),
    .empty_o  (tx_empty)
  );

  // Sticky flags: a set in the same clock as clr_err wins.
  logic parity_err_q, frame_err_q, overrun_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      parity_err_q <= rx_par_bad   | (parity_err_q & ~clr_err);
      frame_err_q  <= rx_frame_bad | (frame_err_q  & ~clr_err);
      overrun_q    <= rx_ovr       | (overrun_q    & ~clr_err);
    end
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: directed reset/loopback/parity/framing/
// FIFO/glitch steps followed by randomized loopback frames.
module tb_uart_param;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int FIFO_W  = 2;
  localparam int DVSR_W  = 11;

  typedef struct packed {
    logic [DBIT-1:0] data;
    logic            par;
    logic            stop;
  } frame_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        par_mode;
  logic              clr_err;
  logic              rx, tx;
  logic              parity_err, frame_err, overrun;
  logic              loop_en, drv_rx, mon_en;

  int     n_assert = 0;
  int     n_fail   = 0;
  frame_t mon_q[$];

  uart_param_if #(.DBIT(DBIT)) bus ();

  assign rx = loop_en ? tx : drv_rx;

  uart_param #(.DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_W(FIFO_W), .DVSR_W(DVSR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .dvsr       (dvsr),
    .par_mode   (par_mode),
    .bus        (bus),
    .rx         (rx),
    .tx         (tx),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (reset || !mon_en) ab = 1'b1;
    end
  endtask

  // Line decoder: samples each bit at its nominal middle.
  always begin : tx_monitor
    int     bp;
    bit     pe, ab;
    frame_t f;
    @(negedge clk);
    if (mon_en && !reset && tx === 1'b0) begin
      bp = 16 * (int'(dvsr) + 1);
      pe = (par_mode == 2'b01) || (par_mode == 2'b10);
      ab = 1'b0;
      f  = '0;
      mon_wait(bp / 2 - 1, ab);
      for (int i = 0; i < DBIT; i++) begin
        mon_wait(bp, ab);
        f.data[i] = tx;
      end
      if (pe) begin
        mon_wait(bp, ab);
        f.par = tx;
      end
      mon_wait(bp, ab);
      f.stop = tx;
      if (!ab) mon_q.push_back(f);
    end
  end

  task automatic write_word(input logic [DBIT-1:0] d);
    bus.wr_uart = 1'b1;
    bus.w_data  = d;
    @(negedge clk);
    bus.wr_uart = 1'b0;
  endtask

  task automatic read_word();
    bus.rd_uart = 1'b1;
    @(negedge clk);
    bus.rd_uart = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int max);
    int i = 0;
    while (bus.rx_empty && i < max) begin
      @(negedge clk);
      i++;
    end
    check({tag, " rx word arrived"}, bus.rx_empty, 1'b0);
  endtask

  task automatic get_frame(input string tag, input int max, output frame_t f);
    int i = 0;
    f = '0;
    while (mon_q.size() == 0 && i < max) begin
      @(negedge clk);
      i++;
    end
    check({tag, " tx frame seen"}, mon_q.size() != 0, 1'b1);
    if (mon_q.size() != 0) f = mon_q.pop_front();
  endtask

  // Drives one frame onto rx with explicit parity and stop values.
  task automatic send_frame(input logic [DBIT-1:0] d, input bit with_par,
                            input logic par_bit, input logic stop_bit);
    int bp = 16 * (int'(dvsr) + 1);
    drv_rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < DBIT; i++) begin
      drv_rx = d[i];
      repeat (bp) @(negedge clk);
    end
    if (with_par) begin
      drv_rx = par_bit;
      repeat (bp) @(negedge clk);
    end
    drv_rx = stop_bit;
    // A bad stop bit is released shortly after mid-bit so it is not mistaken
    // for the start of another frame.
    if (stop_bit) repeat (bp * SB_TICK / 16) @(negedge clk);
    else          repeat (bp * 12 / 16) @(negedge clk);
    drv_rx = 1'b1;
  endtask

  function automatic logic exp_parity(input logic [DBIT-1:0] d, input logic [1:0] pm);
    int ones = $countones(d);
    return (pm == 2'b01) ? logic'((ones + 1) % 2) : logic'(ones % 2);
  endfunction

  initial begin
    frame_t          f;
    int              run;
    logic [DBIT-1:0] d;
    logic [DBIT-1:0] ov_words [5];
    logic [DBIT-1:0] full_words [5];

    reset = 1'b1; dvsr = DVSR_W'(3); par_mode = 2'b00; clr_err = 1'b0;
    loop_en = 1'b0; drv_rx = 1'b1; mon_en = 1'b0;
    bus.wr_uart = 1'b0; bus.w_data = '0; bus.rd_uart = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset tx", tx, 1'b1);
    check("reset rx_empty", bus.rx_empty, 1'b1);
    check("reset tx_full", bus.tx_full, 1'b0);
    check("reset r_data", bus.r_data, 0);
    check("reset flags", {parity_err, frame_err, overrun}, 3'b000);

    // Loopback 8N1, 0xF4
    loop_en = 1'b1; mon_en = 1'b1;
    write_word(8'hF4);
    check("8N1 tx idle at fifo write", tx, 1'b1);
    @(negedge clk);
    check("8N1 start bit one clock after pop", tx, 1'b0);
    run = 0;
    while (tx === 1'b0 && run < 400) begin
      run++;
      @(negedge clk);
    end
    check("8N1 start+bit0+bit1 low run 189..192", (run >= 189 && run <= 192), 1'b1);
    get_frame("8N1", 1500, f);
    check("8N1 line data", f.data, 8'hF4);
    check("8N1 line stop", f.stop, 1'b1);
    wait_rx("8N1", 1500);
    check("8N1 r_data", bus.r_data, 8'hF4);
    check("8N1 flags", {parity_err, frame_err, overrun}, 3'b000);
    read_word();
    check("8N1 rx_empty after read", bus.rx_empty, 1'b1);
    check("8N1 r_data zero when empty", bus.r_data, 0);

    // Even parity, loopback then forced bad parity
    par_mode = 2'b10;
    write_word(8'h03);
    get_frame("even", 1500, f);
    check("even line data", f.data, 8'h03);
    check("even line parity bit", f.par, 1'b0);
    wait_rx("even", 1500);
    check("even r_data", bus.r_data, 8'h03);
    check("even no parity_err", parity_err, 1'b0);
    read_word();
    loop_en = 1'b0;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    wait_rx("bad parity", 200);
    check("bad parity r_data", bus.r_data, 8'h03);
    check("bad parity parity_err", parity_err, 1'b1);
    read_word();
    clear_flags();
    check("clr_err clears parity_err", parity_err, 1'b0);

    // Framing error
    par_mode = 2'b00;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_rx("framing", 200);
    check("framing frame_err", frame_err, 1'b1);
    check("framing word still pushed", bus.r_data, 8'h55);
    read_word();
    repeat (800) @(negedge clk);
    check("framing no spurious word", bus.rx_empty, 1'b1);
    clear_flags();
    check("clr_err clears frame_err", frame_err, 1'b0);

    // Glitch shorter than half a bit
    drv_rx = 1'b0;
    repeat (4 * (int'(dvsr) + 1)) @(negedge clk);
    drv_rx = 1'b1;
    repeat (1400) @(negedge clk);
    check("glitch rx_empty", bus.rx_empty, 1'b1);
    check("glitch flags", {parity_err, frame_err, overrun}, 3'b000);

    // TX FIFO full: one word in the shifter plus four queued
    mon_q.delete();
    for (int i = 0; i < 5; i++) full_words[i] = DBIT'($urandom());
    for (int i = 0; i < 5; i++) write_word(full_words[i]);
    check("tx_full after 5 writes", bus.tx_full, 1'b1);
    for (int i = 0; i < 5; i++) begin
      get_frame("tx fifo", 1500, f);
      check($sformatf("tx fifo word %0d", i), f.data, full_words[i]);
    end
    check("tx_full drained", bus.tx_full, 1'b0);

    // RX overrun: five frames, nothing read
    for (int i = 0; i < 5; i++) ov_words[i] = DBIT'(8'h11 * (i + 1));
    for (int i = 0; i < 5; i++) send_frame(ov_words[i], 1'b0, 1'b0, 1'b1);
    check("overrun set", overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("overrun read %0d", i), bus.r_data, ov_words[i]);
      read_word();
    end
    check("overrun fifo drained", bus.rx_empty, 1'b1);
    check("overrun sticky", overrun, 1'b1);
    clear_flags();
    check("clr_err clears overrun", overrun, 1'b0);

    // Reset in the middle of a TX frame
    mon_en = 1'b0; loop_en = 1'b1;
    write_word(8'h5A);
    repeat (100) @(negedge clk);
    check("mid-frame line low", tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset mid-frame tx high", tx, 1'b1);
    reset = 1'b0;
    repeat (1500) @(negedge clk);
    check("reset mid-frame nothing received", bus.rx_empty, 1'b1);
    check("reset mid-frame line idle", tx, 1'b1);

    // Randomized loopback against the line/parity model
    mon_q.delete();
    mon_en = 1'b1;
    for (int b = 0; b < 2; b++) begin
      dvsr     = DVSR_W'($urandom_range(0, 2));
      par_mode = 2'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) begin
        d = DBIT'($urandom());
        write_word(d);
        get_frame("rand", 1200, f);
        check($sformatf("rand line data b%0d k%0d", b, k), f.data, d);
        if (par_mode == 2'b01 || par_mode == 2'b10)
          check($sformatf("rand line parity b%0d k%0d", b, k), f.par, exp_parity(d, par_mode));
        check($sformatf("rand line stop b%0d k%0d", b, k), f.stop, 1'b1);
        wait_rx("rand", 200);
        check($sformatf("rand r_data b%0d k%0d", b, k), bus.r_data, d);
        read_word();
      end
    end
    check("rand flags clear", {parity_err, frame_err, overrun}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
